// File: rtl/morse_receiver_if.sv
// Morse receiver port bundle.
//   key_in     : raw key from the switch (asynchronous)
//   key_db     : debounced key level
//   data_valid : one-cycle character/space strobe
//   char_index : symbol count minus 1, 3'b101 marks a space
//   char_data  : symbols, dash=1, first symbol in the highest used bit
//   char_err   : one-cycle strobe, character dropped (more than 5 symbols)
// master : the receiver side (drives everything except key_in)
// slave  : the key source / character consumer
interface morse_receiver_if;
  logic       key_in;
  logic       key_db;
  logic       data_valid;
  logic [2:0] char_index;
  logic [5:0] char_data;
  logic       char_err;

  modport master (
    input  key_in,
    output key_db, data_valid, char_index, char_data, char_err
  );

  modport slave (
    output key_in,
    input  key_db, data_valid, char_index, char_data, char_err
  );
endinterface

// File: rtl/morse_receiver.sv
// Morse receiver: synchronises and debounces a raw key, times presses and
// gaps, classifies dot/dash, and emits one strobe per character plus one
// space token per word gap.
// Ports:
//   clk_100Mhz : clock, rising edge
//   reset_n    : asynchronous active-low reset
//   mr         : morse_receiver_if.master (key_in in; key_db, data_valid,
//                char_index, char_data, char_err out)
//
// state | meaning
// IDLE  | no character pending, no space owed
// PRESS | key held, current symbol being timed
// GAP   | key released, symbols pending, waiting for char gap
// WORD  | character emitted, space owed unless key is pressed again
module morse_receiver #(
  parameter int UNIT_CYCLES     = 10_000_000,
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic                clk_100Mhz,
  input  logic                reset_n,
  morse_receiver_if.master    mr
);

  localparam int DUR_MAX = 5 * UNIT_CYCLES;
  localparam int DW      = $clog2(DUR_MAX + 1);
  localparam int CW      = $clog2(DEBOUNCE_CYCLES + 1);

  // Comparisons are made against the count before the edge, so each
  // threshold is checked one below its nominal value: the edge that
  // acts is the one where the count reaches the threshold.
  localparam logic [DW-1:0] DUR_SAT   = DW'(DUR_MAX);
  localparam logic [DW-1:0] DASH_LAST = DW'(2 * UNIT_CYCLES - 1);
  localparam logic [DW-1:0] CHAR_LAST = DW'(2 * UNIT_CYCLES - 1);
  localparam logic [DW-1:0] WORD_LAST = DW'(5 * UNIT_CYCLES - 1);
  localparam logic [CW-1:0] DB_LAST   = CW'(DEBOUNCE_CYCLES);

  typedef enum logic [1:0] {IDLE, PRESS, GAP, WORD} state_t;

  logic          sync1_q, key_s_q;
  logic          key_db_q;
  logic [CW-1:0] db_cnt_q;
  logic [DW-1:0] dur_q;
  logic          db_toggle, db_rise, db_fall, symbol;

  state_t        state_q, state_d;
  logic [2:0]    nsym_q, nsym_d;
  logic [5:0]    sym_buf_q, sym_buf_d;
  logic          ovf_q, ovf_d;
  logic          dv_q, dv_d;
  logic          err_q, err_d;
  logic [2:0]    idx_q, idx_d;
  logic [5:0]    data_q, data_d;

  assign db_toggle = (key_s_q != key_db_q) && (db_cnt_q == DB_LAST);
  assign db_rise   = db_toggle && !key_db_q;
  assign db_fall   = db_toggle &&  key_db_q;
  // dur_q + 1 cycles have elapsed at the falling edge, hence DASH_LAST.
  assign symbol    = (dur_q >= DASH_LAST);

  always_ff @(posedge clk_100Mhz or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q  <= 1'b0;
      key_s_q  <= 1'b0;
      key_db_q <= 1'b0;
      db_cnt_q <= '0;
      dur_q    <= '0;
    end else begin
      sync1_q <= mr.key_in;
      key_s_q <= sync1_q;
      if (key_s_q == key_db_q) begin
        db_cnt_q <= '0;
      end else if (db_toggle) begin
        key_db_q <= ~key_db_q;
        db_cnt_q <= '0;
      end else begin
        db_cnt_q <= db_cnt_q + 1'b1;
      end
      if (db_toggle) begin
        dur_q <= '0;
      end else if (dur_q != DUR_SAT) begin
        dur_q <= dur_q + 1'b1;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    nsym_d    = nsym_q;
    sym_buf_d = sym_buf_q;
    ovf_d     = ovf_q;
    dv_d      = 1'b0;
    err_d     = 1'b0;
    idx_d     = idx_q;
    data_d    = data_q;
    case (state_q)
      IDLE: begin
        if (db_rise) state_d = PRESS;
      end
      PRESS: begin
        if (db_fall) begin
          state_d = GAP;
          if (nsym_q < 3'd5) begin
            sym_buf_d = {sym_buf_q[4:0], symbol};
            nsym_d    = nsym_q + 3'd1;
          end else begin
            ovf_d = 1'b1;
          end
        end
      end
      GAP: begin
        if (dur_q == CHAR_LAST) begin
          if (ovf_q) begin
            err_d = 1'b1;
          end else begin
            dv_d   = 1'b1;
            idx_d  = nsym_q - 3'd1;
            data_d = sym_buf_q;
          end
          nsym_d    = '0;
          sym_buf_d = '0;
          ovf_d     = 1'b0;
          // A press landing on the exact boundary starts a new character.
          state_d   = db_rise ? PRESS : WORD;
        end else if (db_rise) begin
          state_d = PRESS;
        end
      end
      WORD: begin
        if (dur_q == WORD_LAST) begin
          dv_d    = 1'b1;
          idx_d   = 3'b101;
          data_d  = '0;
          state_d = db_rise ? PRESS : IDLE;
        end else if (db_rise) begin
          state_d = PRESS;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_100Mhz or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      nsym_q    <= '0;
      sym_buf_q <= '0;
      ovf_q     <= 1'b0;
      dv_q      <= 1'b0;
      err_q     <= 1'b0;
      idx_q     <= '0;
      data_q    <= '0;
    end else begin
      state_q   <= state_d;
      nsym_q    <= nsym_d;
      sym_buf_q <= sym_buf_d;
      ovf_q     <= ovf_d;
      dv_q      <= dv_d;
      err_q     <= err_d;
      idx_q     <= idx_d;
      data_q    <= data_d;
    end
  end

  assign mr.key_db     = key_db_q;
  assign mr.data_valid = dv_q;
  assign mr.char_err   = err_q;
  assign mr.char_index = idx_q;
  assign mr.char_data  = data_q;

endmodule

// File: tb/tb_morse_receiver.sv
// Directed bench for morse_receiver with UNIT_CYCLES=8, DEBOUNCE_CYCLES=2.
module tb_morse_receiver;
  localparam int UNIT = 8;
  localparam int DEB  = 2;

  logic clk_100Mhz = 1'b0;
  logic reset_n    = 1'b1;
  always #5 clk_100Mhz = ~clk_100Mhz;

  morse_receiver_if mif ();

  morse_receiver #(.UNIT_CYCLES(UNIT), .DEBOUNCE_CYCLES(DEB)) dut (
    .clk_100Mhz (clk_100Mhz),
    .reset_n    (reset_n),
    .mr         (mif)
  );

  typedef struct {
    int         cyc;
    logic       dv;
    logic       err;
    logic [2:0] idx;
    logic [5:0] data;
  } ev_t;

  ev_t  ev_q[$];
  int   fall_q[$];
  int   rise_cnt = 0;
  int   cyc      = 0;
  logic db_prev  = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;
  int ev_base, fall_base, rise_base;

  always @(posedge clk_100Mhz) cyc <= cyc + 1;

  always @(negedge clk_100Mhz) begin
    if (mif.data_valid === 1'b1 || mif.char_err === 1'b1)
      ev_q.push_back('{cyc, mif.data_valid, mif.char_err, mif.char_index, mif.char_data});
    if (db_prev && !mif.key_db) fall_q.push_back(cyc);
    if (!db_prev && mif.key_db) rise_cnt <= rise_cnt + 1;
    db_prev <= mif.key_db;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic start_test();
    ev_base   = ev_q.size();
    fall_base = fall_q.size();
    rise_base = rise_cnt;
  endtask

  task automatic key_hold(input logic v, input int n);
    mif.key_in = v;
    repeat (n) @(negedge clk_100Mhz);
  endtask

  task automatic check_count(input string tag, input int exp);
    check_eq(tag, ev_q.size() - ev_base, exp);
  endtask

  task automatic check_ev(input string tag, input int k, input logic dv, input logic err,
                          input logic [2:0] idx, input logic [5:0] data);
    int i;
    i = ev_base + k;
    if (i < ev_q.size()) begin
      check_eq({tag, "_dv"},   ev_q[i].dv,   dv);
      check_eq({tag, "_err"},  ev_q[i].err,  err);
      check_eq({tag, "_idx"},  ev_q[i].idx,  idx);
      check_eq({tag, "_data"}, ev_q[i].data, data);
    end else begin
      check_eq({tag, "_present"}, ev_q.size(), i + 1);
    end
  endtask

  // Cycles from the f-th key_db fall of this test to the k-th strobe.
  task automatic check_lat(input string tag, input int k, input int f, input int exp);
    int i, j;
    i = ev_base + k;
    j = fall_base + f;
    if (i < ev_q.size() && j < fall_q.size())
      check_eq(tag, ev_q[i].cyc - fall_q[j], exp);
    else
      check_eq({tag, "_present"}, (i < ev_q.size()) && (j < fall_q.size()), 1);
  endtask

  task automatic check_outputs_zero(input string tag);
    check_eq({tag, "_key_db"}, mif.key_db,     0);
    check_eq({tag, "_dv"},     mif.data_valid, 0);
    check_eq({tag, "_idx"},    mif.char_index, 0);
    check_eq({tag, "_data"},   mif.char_data,  0);
    check_eq({tag, "_err"},    mif.char_err,   0);
  endtask

  initial begin
    mif.key_in = 1'b0;
    #1 reset_n = 1'b0;
    repeat (3) @(negedge clk_100Mhz);
    check_outputs_zero("reset");
    reset_n = 1'b1;
    key_hold(0, 5);

    // E: single dot, then space, then silence
    start_test();
    key_hold(1, 8);
    key_hold(0, 150);
    check_count("E_count", 2);
    check_ev("E_char", 0, 1, 0, 3'd0, 6'b000000);
    check_lat("E_char_lat", 0, 0, 16);
    check_ev("E_space", 1, 1, 0, 3'd5, 6'b000000);
    check_lat("E_space_lat", 1, 0, 40);

    // A: dot, dash
    start_test();
    key_hold(1, 8);  key_hold(0, 8);
    key_hold(1, 24); key_hold(0, 80);
    check_count("A_count", 2);
    check_ev("A_char", 0, 1, 0, 3'd1, 6'b000001);
    check_ev("A_space", 1, 1, 0, 3'd5, 6'b000000);

    // B then E after a 20-cycle gap: no space between, one after
    start_test();
    key_hold(1, 24); key_hold(0, 8);
    key_hold(1, 8);  key_hold(0, 8);
    key_hold(1, 8);  key_hold(0, 8);
    key_hold(1, 8);  key_hold(0, 20);
    key_hold(1, 8);  key_hold(0, 80);
    check_count("BE_count", 3);
    check_ev("B_char", 0, 1, 0, 3'd3, 6'b001000);
    check_lat("B_char_lat", 0, 3, 16);
    check_ev("E2_char", 1, 1, 0, 3'd0, 6'b000000);
    check_lat("E2_char_lat", 1, 4, 16);
    check_ev("BE_space", 2, 1, 0, 3'd5, 6'b000000);
    check_lat("BE_space_lat", 2, 4, 40);

    // Six dots: overflow error, then a space
    start_test();
    for (int i = 0; i < 6; i++) begin
      key_hold(1, 8);
      key_hold(0, (i == 5) ? 80 : 8);
    end
    check_count("ovf_count", 2);
    check_ev("ovf_err", 0, 0, 1, 3'd5, 6'b000000);
    check_lat("ovf_err_lat", 0, 5, 16);
    check_ev("ovf_space", 1, 1, 0, 3'd5, 6'b000000);
    check_lat("ovf_space_lat", 1, 5, 40);

    // 1-cycle glitches during idle
    start_test();
    for (int i = 0; i < 5; i++) begin
      key_hold(1, 1);
      key_hold(0, 6);
    end
    key_hold(0, 20);
    check_eq("glitch_rises", rise_cnt - rise_base, 0);
    check_eq("glitch_key_db", mif.key_db, 0);
    check_count("glitch_count", 0);

    // Reset mid-press
    start_test();
    mif.key_in = 1'b1;
    repeat (10) @(negedge clk_100Mhz);
    check_eq("midpress_key_db_before", mif.key_db, 1);
    check_eq("midpress_idx_before", mif.char_index, 5);
    #2 reset_n = 1'b0;
    #1 check_outputs_zero("midpress_rst");
    mif.key_in = 1'b0;
    @(negedge clk_100Mhz);
    @(negedge clk_100Mhz);
    reset_n = 1'b1;
    key_hold(0, 80);
    check_count("midpress_count", 0);

    // Reset mid-gap after three symbols
    start_test();
    key_hold(1, 8); key_hold(0, 8);
    key_hold(1, 8); key_hold(0, 8);
    key_hold(1, 8); key_hold(0, 12);
    #2 reset_n = 1'b0;
    #1 check_outputs_zero("midgap_rst");
    @(negedge clk_100Mhz);
    @(negedge clk_100Mhz);
    reset_n = 1'b1;
    key_hold(0, 80);
    check_count("midgap_count", 0);

    // N decodes cleanly afterwards
    start_test();
    key_hold(1, 24); key_hold(0, 8);
    key_hold(1, 8);  key_hold(0, 80);
    check_count("N_count", 2);
    check_ev("N_char", 0, 1, 0, 3'd1, 6'b000010);
    check_ev("N_space", 1, 1, 0, 3'd5, 6'b000000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
